// File: rtl/lsu_dm_bridge.sv
// Load/store bridge between the CPU MEM stage and a four-bank byte-wide data memory.
// One request in flight at a time: IDLE -> (ACCESS -> [LOAD_WB] ->) RESP -> IDLE.
// Illegal, misaligned or out-of-range requests skip ACCESS and answer with resp_err.
module lsu_dm_bridge #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              dm_cs,
    output logic [3:0]        dm_web,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_di,
    input  logic [31:0]       dm_do
);

    typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WB, RESP} state_t;

    state_t            state, state_n;
    logic [1:0]        lane_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic              accept;
    logic              bad;
    logic              illegal, misaligned, out_of_range;
    logic [3:0]        be;
    logic [31:0]       ld_sh;
    logic [31:0]       ld_ext;

    logic              resp_valid_n, resp_err_n, dm_cs_n;
    logic [31:0]       resp_rdata_n, dm_di_n;
    logic [3:0]        dm_web_n;
    logic [ADDR_W-1:0] dm_addr_n;

    // Only IDLE takes requests, so nothing is ever queued behind a busy access.
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Classify the incoming request before it is allowed near the memory.
    always_comb begin
        if (req_we)
            illegal = (req_funct3 > 3'b010);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr[31:ADDR_W+2] != '0);
        bad          = illegal || misaligned || out_of_range;
    end

    // Store byte-enable pattern before lane shifting; SW covers all four banks.
    always_comb begin
        case (req_funct3)
            3'b000:  be = 4'b0001;
            3'b001:  be = 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Align the read word to the captured lane, then sign/zero-extend by access size.
    always_comb begin
        ld_sh = dm_do >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b010:  ld_ext = ld_sh;
            3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
            3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
            default: ld_ext = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = bad ? RESP : ACCESS;
            ACCESS:  state_n = we_q ? RESP : LOAD_WB;
            LOAD_WB: state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values for the registered outputs; the DM strobes are idle unless entering ACCESS.
    always_comb begin
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = resp_rdata;
        dm_cs_n      = 1'b0;
        dm_web_n     = 4'hF;
        dm_addr_n    = dm_addr;
        dm_di_n      = dm_di;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = 32'd0;
                    end else begin
                        dm_cs_n   = 1'b1;
                        dm_addr_n = req_addr[ADDR_W+1:2];
                        if (req_we) begin
                            dm_web_n = ~(be << req_addr[1:0]);
                            dm_di_n  = req_wdata << {req_addr[1:0], 3'b000};
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    resp_valid_n = 1'b1;
                    resp_rdata_n = 32'd0;
                end
            end
            LOAD_WB: begin
                resp_valid_n = 1'b1;
                resp_rdata_n = ld_ext;
            end
            default: ;
        endcase
    end

    // Output and request-capture registers; reset forces DM writes off immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            dm_cs      <= 1'b0;
            dm_web     <= 4'hF;
            dm_addr    <= '0;
            dm_di      <= 32'd0;
            lane_q     <= 2'd0;
            f3_q       <= 3'd0;
            we_q       <= 1'b0;
        end else begin
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            dm_cs      <= dm_cs_n;
            dm_web     <= dm_web_n;
            dm_addr    <= dm_addr_n;
            dm_di      <= dm_di_n;
            if (accept) begin
                lane_q <= req_addr[1:0];
                f3_q   <= req_funct3;
                we_q   <= req_we;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dm_bridge.sv
// Directed bench for lsu_dm_bridge: stores, loads, error paths, back-to-back and mid-access reset.
module tb_lsu_dm_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        dm_cs;
    logic [3:0]  dm_web;
    logic [13:0] dm_addr;
    logic [31:0] dm_di;
    logic [31:0] dm_do = 32'h5A5A_C3C3;

    int errs = 0;
    int checks = 0;

    lsu_dm_bridge #(.ADDR_W(14)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .dm_cs(dm_cs), .dm_web(dm_web), .dm_addr(dm_addr), .dm_di(dm_di), .dm_do(dm_do)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errs++; $display("FAIL reset_resp_err: got %b exp 0", resp_err); end
        checks++; if (resp_rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata: got %h exp 0", resp_rdata); end
        checks++; if (dm_cs !== 1'b0) begin errs++; $display("FAIL reset_cs: got %b exp 0", dm_cs); end
        checks++; if (dm_web !== 4'hF) begin errs++; $display("FAIL reset_web: got %h exp f", dm_web); end
        checks++; if (dm_addr !== 14'd0) begin errs++; $display("FAIL reset_addr: got %h exp 0", dm_addr); end
        checks++; if (dm_di !== 32'd0) begin errs++; $display("FAIL reset_di: got %h exp 0", dm_di); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        logic [2:0]  f3  [3] = '{3'b010, 3'b000, 3'b001};
        logic [31:0] ad  [3] = '{32'h8000, 32'h8003, 32'h8002};
        logic [31:0] wd  [3] = '{32'hDEADBEEF, 32'h0000_00A5, 32'h0000_1234};
        logic [3:0]  web [3] = '{4'b0000, 4'b0111, 4'b0011};
        logic [31:0] di  [3] = '{32'hDEADBEEF, 32'hA500_0000, 32'h1234_0000};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3[i]; req_addr = ad[i]; req_wdata = wd[i];
            tick();
            req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF;
            checks++; if (dm_cs !== 1'b1) begin errs++; $display("FAIL st%0d_cs: got %b exp 1", i, dm_cs); end
            checks++; if (dm_web !== web[i]) begin errs++; $display("FAIL st%0d_web: got %b exp %b", i, dm_web, web[i]); end
            checks++; if (dm_addr !== 14'h2000) begin errs++; $display("FAIL st%0d_addr: got %h exp 2000", i, dm_addr); end
            checks++; if (dm_di !== di[i]) begin errs++; $display("FAIL st%0d_di: got %h exp %h", i, dm_di, di[i]); end
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errs++; $display("FAIL st%0d_t1: ready=%b rv=%b exp 0 0", i, req_ready, resp_valid); end
            tick();
            checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errs++; $display("FAIL st%0d_resp: rv=%b err=%b exp 1 0", i, resp_valid, resp_err); end
            checks++; if (resp_rdata !== 32'd0) begin errs++; $display("FAIL st%0d_rdata: got %h exp 0", i, resp_rdata); end
            checks++; if (dm_cs !== 1'b0 || dm_web !== 4'hF) begin errs++; $display("FAIL st%0d_idle_dm: cs=%b web=%h exp 0 f", i, dm_cs, dm_web); end
            checks++; if (dm_addr !== 14'h2000 || dm_di !== di[i]) begin errs++; $display("FAIL st%0d_hold: addr=%h di=%h exp 2000 %h", i, dm_addr, dm_di, di[i]); end
            tick();
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL st%0d_done: rv=%b ready=%b exp 0 1", i, resp_valid, req_ready); end
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] ad  [6] = '{32'h8003, 32'h8003, 32'h8002, 32'h8002, 32'h8000, 32'h8001};
        logic [31:0] mem [6] = '{32'hA500_0000, 32'hA500_0000, 32'h8001_1234, 32'h8001_1234, 32'h8001_1234, 32'h0000_7F00};
        logic [31:0] exp [6] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_1234, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3[i]; req_addr = ad[i];
            tick();
            // Scramble the request inputs: the bridge must use its captured copy.
            req_valid = 1'b0; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF;
            checks++; if (dm_cs !== 1'b1 || dm_web !== 4'hF) begin errs++; $display("FAIL ld%0d_access: cs=%b web=%h exp 1 f", i, dm_cs, dm_web); end
            checks++; if (dm_addr !== 14'h2000) begin errs++; $display("FAIL ld%0d_addr: got %h exp 2000", i, dm_addr); end
            tick();
            dm_do = mem[i];
            checks++; if (resp_valid !== 1'b0 || dm_cs !== 1'b0) begin errs++; $display("FAIL ld%0d_wb: rv=%b cs=%b exp 0 0", i, resp_valid, dm_cs); end
            tick();
            dm_do = 32'h5A5A_C3C3;
            checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errs++; $display("FAIL ld%0d_resp: rv=%b err=%b exp 1 0", i, resp_valid, resp_err); end
            checks++; if (resp_rdata !== exp[i]) begin errs++; $display("FAIL ld%0d_rdata: got %h exp %h", i, resp_rdata, exp[i]); end
            tick();
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL ld%0d_done: rv=%b ready=%b exp 0 1", i, resp_valid, req_ready); end
            checks++; if (resp_rdata !== exp[i]) begin errs++; $display("FAIL ld%0d_hold: got %h exp %h", i, resp_rdata, exp[i]); end
        end
    endtask

    task automatic test_error();
        logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011};
        logic [31:0] ad [5] = '{32'h8002, 32'h8001, 32'h0001_0000, 32'h8000, 32'h8000};
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = we[i]; req_funct3 = f3[i]; req_addr = ad[i]; req_wdata = 32'h1111_2222;
            tick();
            req_valid = 1'b0;
            checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errs++; $display("FAIL err%0d_resp: rv=%b err=%b exp 1 1", i, resp_valid, resp_err); end
            checks++; if (resp_rdata !== 32'd0) begin errs++; $display("FAIL err%0d_rdata: got %h exp 0", i, resp_rdata); end
            checks++; if (dm_cs !== 1'b0 || dm_web !== 4'hF) begin errs++; $display("FAIL err%0d_dm: cs=%b web=%h exp 0 f", i, dm_cs, dm_web); end
            checks++; if (dm_addr !== 14'h2000) begin errs++; $display("FAIL err%0d_addr_hold: got %h exp 2000", i, dm_addr); end
            tick();
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dm_cs !== 1'b0) begin errs++; $display("FAIL err%0d_done: rv=%b ready=%b cs=%b exp 0 1 0", i, resp_valid, req_ready, dm_cs); end
        end
    endtask

    task automatic test_back_to_back();
        logic rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic rv  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic cs  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int   nresp = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000; req_wdata = 32'h0BAD_F00D;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 3) req_valid = 1'b0;
            if (resp_valid === 1'b1) nresp++;
            checks++;
            if (req_ready !== rdy[c] || resp_valid !== rv[c] || dm_cs !== cs[c]) begin
                errs++;
                $display("FAIL b2b_c%0d: ready=%b rv=%b cs=%b exp %b %b %b", c + 1, req_ready, resp_valid, dm_cs, rdy[c], rv[c], cs[c]);
            end
        end
        checks++; if (nresp != 2) begin errs++; $display("FAIL b2b_count: got %0d exp 2", nresp); end
    endtask

    task automatic test_reset_mid();
        int nresp = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000; req_wdata = 32'hCAFE_BABE;
        tick();
        req_valid = 1'b0;
        checks++; if (dm_cs !== 1'b1 || dm_web !== 4'h0) begin errs++; $display("FAIL rm_access: cs=%b web=%h exp 1 0", dm_cs, dm_web); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dm_cs !== 1'b0 || dm_web !== 4'hF) begin errs++; $display("FAIL rm_async: cs=%b web=%h exp 0 f", dm_cs, dm_web); end
        checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL rm_rv: got %b exp 0", resp_valid); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (resp_valid === 1'b1) nresp++;
        end
        checks++; if (nresp != 0) begin errs++; $display("FAIL rm_no_resp: got %0d exp 0", nresp); end
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rm_ready: got %b exp 1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
